// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI4-Lite channel structs, response codes and register bank FSM states
package axi_pkg;

  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic        rready;
  } axi_lite_mosi;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } axi_lite_miso;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t OKAY   = 2'b00;
  localparam axi_resp_t SLVERR = 2'b10;
  localparam axi_resp_t DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_D, W_WAIT_A, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_addr_decode.sv
// rtl/axil_addr_decode.sv - byte address to register index and AXI response
// Purely combinational; one instance serves each channel.
module axil_addr_decode
  import axi_pkg::*;
#(
  parameter int              N_REGS    = 8,
  parameter logic [31:0]     BASE_ADDR = 32'h0,
  parameter logic [N_REGS-1:0] RO_MASK = '0,
  parameter int              IDX_W     = $clog2(N_REGS)
) (
  input  logic [31:0]      addr,
  input  logic             is_write,
  output logic [IDX_W-1:0] idx,
  output axi_resp_t        resp
);

  logic [31:0] off;
  logic [29:0] word;

  always_comb begin
    off  = addr - BASE_ADDR;
    word = off[31:2];
    idx  = word[IDX_W-1:0];
    resp = OKAY;
    if (off[1:0] != 2'b00 || word >= 30'(N_REGS)) begin
      resp = DECERR;
    end else if (is_write && (idx == '0 || RO_MASK[idx])) begin
      // register 0 is the version word, so it is never writable
      resp = SLVERR;
    end
  end

endmodule

// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - AXI4-Lite register bank with independent read/write FSMs
// Optional byte-enable writes: define AXIL_REG_BANK_WSTRB_EN.
module axil_reg_bank
  import axi_pkg::*;
#(
  parameter int                N_REGS    = 8,
  parameter logic [31:0]       BASE_ADDR = 32'h0,
  parameter logic [31:0]       VERSION   = 32'h2904_2023,
  parameter logic [N_REGS-1:0] RO_MASK   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  axi_lite_mosi           axio_i,
  output axi_lite_miso           axii_o,
  input  logic [N_REGS-1:0][31:0] stat_i,
  output logic [N_REGS-1:0][31:0] ctrl_o,
  output logic [N_REGS-1:0]      wr_pulse_o
);

  localparam int IDX_W = $clog2(N_REGS);

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  axi_resp_t   bresp_q, bresp_d;
  axi_resp_t   rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [N_REGS-1:0]       wr_pulse_q, wr_pulse_d;
  logic [N_REGS-1:0][31:0] regs_q, regs_d;

  logic             commit;
  logic [31:0]      wr_addr;
  logic [31:0]      commit_data;
  logic [3:0]       commit_strb;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  axi_resp_t        wr_resp, rd_resp;
  logic             unused_sink;

  // In W_WAIT_D the address was captured earlier; otherwise it arrives this cycle.
  assign wr_addr = (wr_state_q == W_WAIT_D) ? aw_addr_q : axio_i.awaddr;

  axil_addr_decode #(
    .N_REGS(N_REGS), .BASE_ADDR(BASE_ADDR), .RO_MASK(RO_MASK), .IDX_W(IDX_W)
  ) u_wr_decode (
    .addr(wr_addr), .is_write(1'b1), .idx(wr_idx), .resp(wr_resp)
  );

  axil_addr_decode #(
    .N_REGS(N_REGS), .BASE_ADDR(BASE_ADDR), .RO_MASK(RO_MASK), .IDX_W(IDX_W)
  ) u_rd_decode (
    .addr(axio_i.araddr), .is_write(1'b0), .idx(rd_idx), .resp(rd_resp)
  );

  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      if (i == 0)           ctrl_o[i] = VERSION;
      else if (RO_MASK[i])  ctrl_o[i] = stat_i[i];
      else                  ctrl_o[i] = regs_q[i];
    end
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    aw_addr_d   = aw_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bresp_d     = bresp_q;
    wr_pulse_d  = '0;
    regs_d      = regs_q;
    commit      = 1'b0;
    commit_data = axio_i.wdata;
    commit_strb = axio_i.wstrb;
    case (wr_state_q)
      W_IDLE: begin
        if (axio_i.awvalid && axio_i.wvalid) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
        end else if (axio_i.awvalid) begin
          aw_addr_d  = axio_i.awaddr;
          wr_state_d = W_WAIT_D;
        end else if (axio_i.wvalid) begin
          w_data_d   = axio_i.wdata;
          w_strb_d   = axio_i.wstrb;
          wr_state_d = W_WAIT_A;
        end
      end
      W_WAIT_D: begin
        if (axio_i.wvalid) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_WAIT_A: begin
        if (axio_i.awvalid) begin
          commit      = 1'b1;
          commit_data = w_data_q;
          commit_strb = w_strb_q;
          wr_state_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (axio_i.bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase

    if (commit) begin
      bresp_d = wr_resp;
      if (wr_resp == OKAY) begin
        wr_pulse_d[wr_idx] = 1'b1;
`ifdef AXIL_REG_BANK_WSTRB_EN
        for (int b = 0; b < 4; b++) begin
          if (commit_strb[b]) regs_d[wr_idx][8*b +: 8] = commit_data[8*b +: 8];
        end
`else
        regs_d[wr_idx] = commit_data;
`endif
      end
    end
  end

  // Read data is taken from the pre-edge register view, so a same-cycle write is not visible.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (axio_i.arvalid) begin
          rresp_d    = rd_resp;
          rdata_d    = (rd_resp == OKAY) ? ctrl_o[rd_idx] : 32'h0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axio_i.rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= OKAY;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      regs_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    axii_o         = '0;
    axii_o.awready = (wr_state_q == W_IDLE) || (wr_state_q == W_WAIT_A);
    axii_o.wready  = (wr_state_q == W_IDLE) || (wr_state_q == W_WAIT_D);
    axii_o.bvalid  = (wr_state_q == W_RESP);
    axii_o.bresp   = bresp_q;
    axii_o.arready = (rd_state_q == R_IDLE);
    axii_o.rvalid  = (rd_state_q == R_DATA);
    axii_o.rdata   = rdata_q;
    axii_o.rresp   = rresp_q;
  end

  assign wr_pulse_o = wr_pulse_q;

  // Storage behind register 0 / RO slots and unmasked status words are intentionally unread.
  assign unused_sink = ^{stat_i, regs_q, commit_strb};

endmodule

// File: tb/tb_axil_reg_bank.sv
// tb/tb_axil_reg_bank.sv - randomized scoreboard bench for axil_reg_bank
module tb_axil_reg_bank;
  import axi_pkg::*;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] VER  = 32'h2904_2023;
  localparam logic [N-1:0] ROM = 8'h80;

  logic clk = 1'b0;
  logic rst;
  axi_lite_mosi axio;
  axi_lite_miso axii;
  logic [N-1:0][31:0] stat, ctrl;
  logic [N-1:0] wr_pulse;

  logic awvalid, wvalid, arvalid, rready, bready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0] wstrb;
  logic r_hold, b_hold;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [N];
  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  rexp_t rq[$];
  logic [1:0] bq[$];

  always #5 clk = ~clk;

  always_comb begin
    axio         = '0;
    axio.awvalid = awvalid;
    axio.awaddr  = awaddr;
    axio.wvalid  = wvalid;
    axio.wdata   = wdata;
    axio.wstrb   = wstrb;
    axio.bready  = bready;
    axio.arvalid = arvalid;
    axio.araddr  = araddr;
    axio.rready  = rready;
  end

  axil_reg_bank #(
    .N_REGS(N), .BASE_ADDR(BASE), .VERSION(VER), .RO_MASK(ROM)
  ) dut (
    .clk(clk), .rst(rst), .axio_i(axio), .axii_o(axii),
    .stat_i(stat), .ctrl_o(ctrl), .wr_pulse_o(wr_pulse)
  );

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] model_resp(logic [31:0] addr, bit wr);
    logic [31:0] off;
    logic [N-1:0] m;
    off = addr - BASE;
    if (off % 4 != 0 || off / 4 >= N) return DECERR;
    m = ROM >> (off / 4);
    if (wr && (off / 4 == 0 || m[0])) return SLVERR;
    return OKAY;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] addr);
    int w;
    logic [N-1:0] m;
    if (model_resp(addr, 1'b0) != OKAY) return 32'h0;
    w = int'((addr - BASE) / 4);
    m = ROM >> w;
    if (w == 0) return VER;
    if (m[0]) return stat[w];
    return mem[w];
  endfunction

  function automatic void model_write(logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    logic [31:0] keep;
    int w;
    if (model_resp(addr, 1'b1) != OKAY) return;
    w = int'((addr - BASE) / 4);
`ifdef AXIL_REG_BANK_WSTRB_EN
    keep = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
`else
    keep = (strb == strb) ? 32'hFFFF_FFFF : 32'h0;
`endif
    mem[w] = (mem[w] & ~keep) | (data & keep);
  endfunction

  function automatic logic [N-1:0][31:0] exp_ctrl();
    logic [N-1:0][31:0] v;
    for (int i = 0; i < N; i++) v[i] = model_read(BASE + 32'(4 * i));
    return v;
  endfunction

  task automatic drive_chan(bit do_aw, bit do_w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    int n = 0;
    bit aw_pend = do_aw;
    bit w_pend = do_w;
    awvalid = do_aw; awaddr = a;
    wvalid = do_w; wdata = d; wstrb = s;
    while ((aw_pend || w_pend) && n < 200) begin
      @(negedge clk);
      n++;
      if (aw_pend && axii.awready) aw_pend = 0;
      if (w_pend && axii.wready) w_pend = 0;
      @(posedge clk); #1;
      if (!aw_pend) awvalid = 1'b0;
      if (!w_pend) wvalid = 1'b0;
    end
    check("write_handshake_timeout", {aw_pend, w_pend}, 0);
  endtask

  task automatic issue_write(logic [31:0] a, logic [31:0] d, logic [3:0] s,
                             int order, int gap, bit wait_b);
    logic [1:0] er;
    logic [N-1:0] ep;
    int n = 0;
    er = model_resp(a, 1'b1);
    ep = (er == OKAY) ? (N'(1) << ((a - BASE) / 4)) : '0;
    model_write(a, d, s);
    bq.push_back(er);
    case (order)
      1: begin
        drive_chan(1, 0, a, d, s);
        repeat (gap) @(posedge clk);
        #1;
        drive_chan(0, 1, a, d, s);
      end
      2: begin
        drive_chan(0, 1, a, d, s);
        repeat (gap) @(posedge clk);
        #1;
        drive_chan(1, 0, a, d, s);
      end
      default: drive_chan(1, 1, a, d, s);
    endcase
    @(negedge clk);
    check("wr_pulse_after_commit", wr_pulse, ep);
    check("bvalid_after_commit", axii.bvalid, 1'b1);
    check("ctrl_after_commit", ctrl, exp_ctrl());
    @(negedge clk);
    check("wr_pulse_single", wr_pulse, 0);
    if (wait_b) begin
      while (bq.size() != 0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("b_response_timeout", bq.size(), 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue_read(logic [31:0] a);
    rexp_t e;
    int n = 0;
    e.resp = model_resp(a, 1'b0);
    e.data = model_read(a);
    rq.push_back(e);
    arvalid = 1'b1; araddr = a;
    do begin
      @(negedge clk);
      n++;
    end while (!axii.arready && n < 200);
    check("ar_handshake_timeout", axii.arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_latency", axii.rvalid, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", rq.size() + bq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_readies"}, {axii.awready, axii.wready, axii.arready}, 3'b111);
    check({tag, "_valids"}, {axii.bvalid, axii.rvalid}, 2'b00);
    check({tag, "_ctrl"}, ctrl, exp_ctrl());
    check({tag, "_wr_pulse"}, wr_pulse, 0);
  endtask

  // Ready generator with optional stall hold per channel
  initial begin
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rready = !r_hold && ($urandom_range(0, 3) != 0);
      bready = !b_hold && ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops expectations on each handshake and checks stability under stall
  initial begin
    logic [31:0] prev_rdata;
    logic [1:0]  prev_rresp, prev_bresp;
    bit r_stalled = 0;
    bit b_stalled = 0;
    rexp_t e;
    logic [1:0] eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_stalled = 0;
        b_stalled = 0;
      end else begin
        if (r_stalled && axii.rvalid) check("r_stable", {axii.rresp, axii.rdata}, {prev_rresp, prev_rdata});
        if (b_stalled && axii.bvalid) check("b_stable", axii.bresp, prev_bresp);
        if (axii.rvalid && rready) begin
          if (rq.size() == 0) check("r_unexpected", 1, 0);
          else begin
            e = rq.pop_front();
            check("rdata", axii.rdata, e.data);
            check("rresp", axii.rresp, e.resp);
          end
        end
        if (axii.bvalid && bready) begin
          if (bq.size() == 0) check("b_unexpected", 1, 0);
          else begin
            eb = bq.pop_front();
            check("bresp", axii.bresp, eb);
          end
        end
        r_stalled  = axii.rvalid && !rready;
        b_stalled  = axii.bvalid && !bready;
        prev_rdata = axii.rdata;
        prev_rresp = axii.rresp;
        prev_bresp = axii.bresp;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rexp_t e;
    int r;
    rst = 1'b1;
    r_hold = 1'b0; b_hold = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    for (int i = 0; i < N; i++) begin
      stat[i] = $urandom;
      mem[i]  = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_resp_rdata", {axii.bresp, axii.rresp, axii.rdata}, 0);
    @(posedge clk); #1;

    issue_read(32'h0);
    issue_write(32'h0C, 32'hDEAD_BEEF, 4'hF, 1, 2, 1);
    issue_read(32'h0C);
    issue_write(32'h14, 32'h1234_5678, 4'hF, 2, 3, 1);
    issue_read(32'h14);
    issue_write(32'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
    issue_read(32'h00);
    issue_write(32'h1C, 32'h5555_AAAA, 4'hF, 0, 0, 1);
    issue_read(32'h1C);
    issue_read(32'(4 * N));
    issue_read(32'h2);
    issue_write(32'h08, 32'h1122_3344, 4'hF, 0, 0, 1);
    issue_write(32'h08, 32'hAABB_CCDD, 4'b0101, 0, 0, 1);
    issue_read(32'h08);
`ifdef AXIL_REG_BANK_WSTRB_EN
    check("wstrb_merge_ctrl", ctrl[2], 32'h11BB_33DD);
`else
    check("wstrb_ignored_ctrl", ctrl[2], 32'hAABB_CCDD);
`endif
    drain();

    // Read and write commit to the same register on one edge: read sees the old value
    e.resp = OKAY;
    e.data = model_read(32'h0C);
    rq.push_back(e);
    model_write(32'h0C, 32'h0BAD_F00D, 4'hF);
    bq.push_back(OKAY);
    awvalid = 1; awaddr = 32'h0C; wvalid = 1; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    arvalid = 1; araddr = 32'h0C;
    @(negedge clk);
    check("same_cycle_readies", {axii.awready, axii.wready, axii.arready}, 3'b111);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    drain();

    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 10);
      if (r < N) a = BASE + 32'(4 * r);
      else if (r == 8) a = BASE + 32'(4 * N);
      else if (r == 9) a = BASE + 32'(4 * $urandom_range(0, N - 1) + $urandom_range(1, 3));
      else a = BASE + 32'h1000;
      if ($urandom_range(0, 1) == 0) issue_read(a);
      else issue_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3), 1);
    end
    drain();

    // Long stall on both channels, then reset drops the in-flight responses
    r_hold = 1'b1; b_hold = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    issue_write(32'h10, 32'hCAFE_0010, 4'hF, 0, 0, 0);
    issue_read(32'h10);
    repeat (10) @(negedge clk);
    check("stall_valids", {axii.rvalid, axii.bvalid}, 2'b11);
    check("stall_rdata", axii.rdata, model_read(32'h10));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_drops_valids", {axii.rvalid, axii.bvalid}, 2'b00);
    rq.delete();
    bq.delete();
    for (int i = 0; i < N; i++) mem[i] = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    r_hold = 1'b0; b_hold = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    @(posedge clk); #1;
    issue_read(32'h10);
    issue_read(32'h0C);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
